// File: rtl/rnn_input_feeder.sv
// rnn_input_feeder
// Input-vector buffer in front of the RNN core. Host vectors are queued in a
// circular FIFO; once a whole sequence is buffered the core is launched with
// `ready`, then each `i_en` request from the core pops one vector onto `idata`.
// A trailing request after the last timestep is absorbed by returning zero.
module rnn_input_feeder #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    input  logic [10:0] seq_len,
    input  logic        busy,
    input  logic        i_en,
    output logic        ready,
    output logic [31:0] idata,
    output logic [AW:0] level,
    output logic        done,
    output logic        underflow
);

    // Occupancy value meaning "every slot holds a word".
    localparam logic [AW:0] LP_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;

    logic [31:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]  r_level;

    logic [10:0]  r_len;
    logic [10:0]  r_served;
    logic [31:0]  r_idata;
    logic         r_done;
    logic         r_underflow;

    logic         w_ready;
    logic         w_push;
    logic         w_pop;
    logic         w_empty;
    logic         w_req_live;
    logic         w_starve;
    logic [10:0]  w_level_ext;
    logic         w_enough;
    logic         w_launch;
    logic         w_finish;

    // FIFO handshake: full blocks pushes even when a pop happens the same cycle,
    // and nothing is accepted while reset is held.
    assign s_ready     = (r_level != LP_FULL) && reset;
    assign w_push      = s_valid && s_ready;
    assign w_empty     = (r_level == '0);

    // A request is "live" while the current sequence still owes timesteps.
    assign w_req_live  = i_en && (r_served < r_len);
    assign w_pop       = w_req_live && !w_empty;
    assign w_starve    = w_req_live && w_empty;

    // Launch check: occupancy zero-extended to the 11-bit length domain, so a
    // length larger than the FIFO can never be satisfied. Zero length never launches.
    assign w_level_ext = 11'(r_level);
    assign w_enough    = (seq_len != 11'd0) && (w_level_ext >= seq_len);
    assign w_launch    = (r_state == ST_IDLE) && w_enough;
    assign w_finish    = (r_state == ST_RUN) && !busy;

    // Storage array: data only, no reset needed since pointers gate validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= s_data;
        end
    end

    // Write/read pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Occupancy counter; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Registered vector to the core: head word on a served request, zero on a
    // starved or trailing request, held otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idata <= '0;
        end else if (i_en) begin
            r_idata <= w_pop ? r_mem[r_rptr] : 32'd0;
        end
    end

    // Sequence bookkeeping: length latched at launch, served count restarts
    // there; a launch on the same edge as a pop takes precedence for the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len    <= '0;
            r_served <= '0;
        end else if (w_launch) begin
            r_len    <= seq_len;
            r_served <= '0;
        end else if (w_pop) begin
            r_served <= r_served + 11'd1;
        end
    end

    // Sticky starvation flag; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_underflow <= 1'b0;
        end else if (w_starve) begin
            r_underflow <= 1'b1;
        end
    end

    // One-cycle completion pulse after the core drops busy in RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_finish;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and launch-request decode.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_ready = 1'b1;
                if (busy) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_finish) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ready     = w_ready;
    assign idata     = r_idata;
    assign level     = r_level;
    assign done      = r_done;
    assign underflow = r_underflow;

endmodule

// File: doc/rnn_input_feeder.md
# rnn_input_feeder

Input-vector buffer that sits directly upstream of the RNN core. It accepts 32-bit input vectors (one per timestep, bit j = input feature j) from a host stream into a FIFO. It launches the core with `ready` once a full sequence is buffered, then serves one vector per `i_en` request from the core on `idata`.

## Interface
- `DEPTH`, 64: FIFO depth in words; power of two, ≥2.
- `AW`, 6: log2(`DEPTH`).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Clears all state immediately on assertion; release is synchronous to `clk`.
- `s_valid`  in  1  host word valid.
- `s_data`  in  32  host input vector.
- `s_ready`  out  1  FIFO can accept a word; combinational, `= (level != DEPTH) && reset`.
- `seq_len`  in  11  number of timesteps in the next sequence; sampled on the IDLE→LAUNCH transition.
- `busy`  in  1  core busy flag.
- `i_en`  in  1  core request for the next input vector (single-cycle pulse).
- `ready`  out  1  launch request to the core.
- `idata`  out  32  registered vector presented to the core.
- `level`  out  AW+1  FIFO occupancy, 0..`DEPTH`.
- `done`  out  1  one-cycle pulse when a sequence finishes.
- `underflow`  out  1  sticky error flag.

## Operation
- **FIFO:** `DEPTH`-entry circular buffer with `AW`-bit write and read pointers that wrap from `DEPTH-1` to 0.
  - Push when `s_valid && s_ready`.
  - Pop as defined below.
  - Push and pop in the same cycle: `level` unchanged. At full, no push is accepted even if a pop occurs that cycle.
- **State machine:** IDLE, LAUNCH, RUN.
  - IDLE: if `seq_len != 0` and `level >= seq_len`, latch `seq_len` into `len_q`, clear `served`, go to LAUNCH. `seq_len == 0` never launches.
  - LAUNCH: `ready = 1`. On `busy == 1`, go to RUN.
  - RUN: `ready = 0`. On `busy == 0`, pulse `done` and return to IDLE.
- **Serving:** in any state, an `i_en` pulse is handled as follows:
  - If `served < len_q` and FIFO not empty: `idata <=` FIFO head, pop, `served <= served + 1`.
  - If `served < len_q` and FIFO empty: `idata <= 0`, set `underflow`, `served` unchanged.
  - If `served == len_q`: `idata <= 0`, no pop, no error. The core issues one trailing request after the last timestep; this case absorbs it.
- **Width rules:**
  - `served` and `len_q` are 11 bits.
  - The `level >= seq_len` compare is unsigned, with `level` zero-extended to 11 bits. `seq_len > DEPTH` therefore never launches.
- `underflow` clears only on reset.
- Host pushes are accepted in every state, so the next sequence may be pre-buffered during RUN.

## Timing
- **Reset values:** `ready = 0`, `idata = 0`, `done = 0`, `underflow = 0`, `level = 0`, state = IDLE, pointers = 0. `s_ready = 0` while `reset` is low.
- **Launch latency:** `ready` rises the cycle after the edge on which `level >= seq_len` is first seen in IDLE. A word pushed on edge N launches at the earliest at edge N+1, with `ready` high after edge N+1.
- **Request latency:** `i_en` high at edge N makes `idata` valid from edge N until the next `i_en`. The core samples `idata` one cycle after its request.
- `ready` stays high until the first edge on which `busy` is sampled high, then drops on that edge.
- `done` is high for exactly one cycle, following the edge on which `busy` is sampled low in RUN.
- **Reset mid-operation:** the FIFO is flushed, state returns to IDLE, and buffered words are lost.

## Test plan
- **Basic sequence:** push 3 words 0xA5A5A5A5, 0x00000001, 0xFFFFFFFF with `seq_len=3`.
  - `ready` rises 1 cycle after the 3rd push.
  - Drive `busy` high, then 4 `i_en` pulses: `idata` = 0xA5A5A5A5, 0x00000001, 0xFFFFFFFF, then 0. `level` = 0, `underflow` = 0.
  - Drop `busy`: `done` pulses once.
- **No early launch:** `seq_len=5`, push 4 words → `ready` stays 0. Push a 5th → `ready` = 1 next cycle.
- **Full FIFO:** push 64 words with `s_valid` held high → `level` = 64, `s_ready` = 0, 65th word not accepted. A simultaneous push and pop at full → `level` = 63.
- **Underflow:** `seq_len=2`, launch, then issue 3 `i_en` pulses while the host removes nothing beyond 2 words buffered after a forced early pop → `underflow` = 1 and stays 1 until reset.
- **Pre-buffering and wrap:** `seq_len=40`, run two back-to-back sequences with the second pushed during RUN of the first. Pointers wrap past 63 and all 80 words appear in order.
- **Reset mid-RUN:** assert `reset` low mid-RUN → `ready`, `idata`, `level` = 0 immediately. After release, state is IDLE with no `done` pulse.
